// File: rtl/mips_hazard_ctl.sv
// Pipeline interlock/flush controller for the five-stage MIPS pipeline: load-use,
// EX-resolved redirects, and a sequenced multi-cycle multiply/divide unit.
module mips_hazard_ctl #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ID_rs,
   input  logic [4:0]  ID_rt,
   input  logic        ID_uses_rt,
   input  logic        EX_MemRead,
   input  logic [4:0]  EX_rt,
   input  logic        EX_redirect,
   input  logic        ID_md_start,
   input  logic        ID_md_div,
   input  logic        ID_md_read,
   output logic        Stall,
   output logic        ID_bubble,
   output logic        IF_flush,
   output logic        md_busy,
   output logic        md_done,
   output logic [15:0] stall_count
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
   localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

   state_t     state;
   logic [5:0] cnt;
   logic       load_use;
   logic       md_struct;
   logic       md_raw;
   logic       accept;
   logic [5:0] cnt_init;

   always_comb begin
      load_use  = EX_MemRead && (EX_rt != 5'd0) &&
                  ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));
      md_struct = ID_md_start && (state == BUSY);
      md_raw    = ID_md_read && (state != IDLE);
      // A redirect kills the ID instruction, so it can never be the one stalling.
      Stall     = !EX_redirect && (load_use || md_struct || md_raw);
      IF_flush  = EX_redirect;
      ID_bubble = Stall || EX_redirect;
      accept    = ID_md_start && !Stall && !EX_redirect && (state != BUSY);
      cnt_init  = ID_md_div ? DIV_CNT : MUL_CNT;
   end

   assign md_busy = (state == BUSY);
   assign md_done = (state == DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 6'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= BUSY;
                  cnt   <= cnt_init;
               end
            end
            BUSY: begin
               if (cnt == 6'd1) state <= DONE;
               else             cnt   <= cnt - 6'd1;
            end
            DONE: begin
               // Back-to-back issue: the next op starts in the cycle HI/LO is written.
               if (accept) begin
                  state <= BUSY;
                  cnt   <= cnt_init;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_count <= 16'd0;
      else if (Stall && (stall_count != 16'hFFFF))
         stall_count <= stall_count + 16'd1;
   end

endmodule

// File: tb/tb_mips_hazard_ctl.sv
// Directed bench for mips_hazard_ctl: hazards, redirect priority, mult/div
// sequencing, asynchronous reset and stall counter saturation.
module tb_mips_hazard_ctl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  ID_rs, ID_rt, EX_rt;
   logic        ID_uses_rt, EX_MemRead, EX_redirect;
   logic        ID_md_start, ID_md_div, ID_md_read;
   logic        Stall, ID_bubble, IF_flush, md_busy, md_done;
   logic [15:0] stall_count;

   int n_chk = 0;
   int n_err = 0;
   int exp_sc = 0;
   logic saw_done;

   mips_hazard_ctl #(.MUL_LAT(4), .DIV_LAT(32)) dut (
      .clk(clk), .reset(reset),
      .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
      .EX_MemRead(EX_MemRead), .EX_rt(EX_rt), .EX_redirect(EX_redirect),
      .ID_md_start(ID_md_start), .ID_md_div(ID_md_div), .ID_md_read(ID_md_read),
      .Stall(Stall), .ID_bubble(ID_bubble), .IF_flush(IF_flush),
      .md_busy(md_busy), .md_done(md_done), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rt = 1'b0;
      EX_MemRead = 1'b0; EX_rt = 5'd0; EX_redirect = 1'b0;
      ID_md_start = 1'b0; ID_md_div = 1'b0; ID_md_read = 1'b0;
   endtask

   initial begin
      clear_in();
      reset = 1'b0;
      #1;
      chk("rst_busy", 32'(md_busy), 32'd0);
      chk("rst_done", 32'(md_done), 32'd0);
      chk("rst_count", 32'(stall_count), 32'd0);
      chk("rst_stall", 32'(Stall), 32'd0);
      tick(); tick();
      reset = 1'b1;
      tick();

      // load-use through rs
      EX_MemRead = 1'b1; EX_rt = 5'd5; ID_rs = 5'd5;
      #1;
      chk("lu_stall", 32'(Stall), 32'd1);
      chk("lu_bubble", 32'(ID_bubble), 32'd1);
      chk("lu_flush", 32'(IF_flush), 32'd0);
      tick(); exp_sc++;
      clear_in(); #1;
      chk("lu_count", 32'(stall_count), 32'(exp_sc));
      chk("lu_clear", 32'(Stall), 32'd0);

      // r0 never hazards; rt path depends on ID_uses_rt
      EX_MemRead = 1'b1; EX_rt = 5'd0; ID_rs = 5'd0; #1;
      chk("lu_r0", 32'(Stall), 32'd0);
      EX_rt = 5'd7; ID_rt = 5'd7; ID_rs = 5'd3; ID_uses_rt = 1'b1; #1;
      chk("lu_rt", 32'(Stall), 32'd1);
      ID_uses_rt = 1'b0; #1;
      chk("lu_rt_unused", 32'(Stall), 32'd0);
      clear_in();

      // redirect beats stall
      EX_MemRead = 1'b1; EX_rt = 5'd5; ID_rs = 5'd5; EX_redirect = 1'b1; #1;
      chk("rd_stall", 32'(Stall), 32'd0);
      chk("rd_flush", 32'(IF_flush), 32'd1);
      chk("rd_bubble", 32'(ID_bubble), 32'd1);
      tick();
      clear_in(); #1;
      chk("rd_count", 32'(stall_count), 32'(exp_sc));

      // multiply, followed by mfhi held in ID
      ID_md_start = 1'b1; ID_md_div = 1'b0; #1;
      chk("mul_issue_stall", 32'(Stall), 32'd0);
      tick();
      ID_md_start = 1'b0; ID_md_read = 1'b1; #1;
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("mul_busy_t%0d", k), 32'(md_busy), 32'(k < 4));
         chk($sformatf("mul_done_t%0d", k), 32'(md_done), 32'(k == 4));
         chk($sformatf("mul_mfhi_t%0d", k), 32'(Stall), 32'd1);
         tick(); exp_sc++;
      end
      chk("mul_idle_busy", 32'(md_busy), 32'd0);
      chk("mul_idle_done", 32'(md_done), 32'd0);
      chk("mul_mfhi_go", 32'(Stall), 32'd0);
      chk("mul_count", 32'(stall_count), 32'(exp_sc));
      clear_in();

      // back-to-back divides
      ID_md_start = 1'b1; ID_md_div = 1'b1; #1;
      chk("div1_issue", 32'(Stall), 32'd0);
      tick();
      for (int k = 1; k <= 31; k++) begin
         chk($sformatf("div1_busy_t%0d", k), 32'(md_busy), 32'd1);
         chk($sformatf("div2_hold_t%0d", k), 32'(Stall), 32'd1);
         tick(); exp_sc++;
      end
      chk("div1_done", 32'(md_done), 32'd1);
      chk("div2_accept", 32'(Stall), 32'd0);
      tick();
      ID_md_start = 1'b0; #1;
      for (int k = 33; k <= 63; k++) begin
         chk($sformatf("div2_busy_t%0d", k), 32'(md_busy), 32'd1);
         chk($sformatf("div2_nodone_t%0d", k), 32'(md_done), 32'd0);
         tick();
      end
      chk("div2_done", 32'(md_done), 32'd1);
      tick();
      chk("div2_idle", 32'(md_done | md_busy), 32'd0);
      chk("div_count", 32'(stall_count), 32'(exp_sc));
      clear_in();

      // redirect blocks a start in ID the same cycle
      ID_md_start = 1'b1; EX_redirect = 1'b1;
      tick();
      chk("rd_block_start", 32'(md_busy), 32'd0);
      clear_in();

      // redirect does not abort an operation in flight
      ID_md_start = 1'b1; tick();
      ID_md_start = 1'b0; EX_redirect = 1'b1; tick();
      EX_redirect = 1'b0; #1;
      chk("rd_keep_busy", 32'(md_busy), 32'd1);
      tick(); tick();
      chk("rd_keep_done", 32'(md_done), 32'd1);
      tick();
      clear_in();

      // asynchronous reset mid-divide
      ID_md_start = 1'b1; ID_md_div = 1'b1; tick();
      ID_md_start = 1'b0;
      for (int k = 1; k < 10; k++) tick();
      chk("rst_mid_busy_pre", 32'(md_busy), 32'd1);
      #2 reset = 1'b0; #1;
      chk("rst_mid_busy", 32'(md_busy), 32'd0);
      chk("rst_mid_count", 32'(stall_count), 32'd0);
      tick();
      reset = 1'b1;
      saw_done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (md_done) saw_done = 1'b1;
      end
      chk("rst_no_done", 32'(saw_done), 32'd0);
      clear_in();

      // saturation of the stall counter
      EX_MemRead = 1'b1; EX_rt = 5'd5; ID_rs = 5'd5;
      for (int k = 0; k < 70000; k++) tick();
      chk("sat_count", 32'(stall_count), 32'h0000FFFF);
      tick(); tick();
      chk("sat_hold", 32'(stall_count), 32'h0000FFFF);
      clear_in();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/mips_hazard_ctl.md
# mips_hazard_ctl

Pipeline interlock and flush controller for the five-stage MIPS pipeline.
- Decides each cycle whether the IF/ID register holds, whether a bubble enters ID/EX, and whether IF/ID is squashed.
- Covers load-use hazards, taken branches/jumps resolved in EX, and a multi-cycle multiply/divide unit, which it sequences with a busy countdown FSM.
- Sits beside the ID stage. Its outputs drive the IF/ID hold mux, the control-zeroing mux before the ID/EX register, and the HI/LO write enable.

## Interface
Parameters:
- MUL_LAT, 4, multiply latency in cycles; legal range 2..63
- DIV_LAT, 32, divide latency in cycles; legal range 2..63

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- ID_rs  in  5  rs field of the instruction in ID
- ID_rt  in  5  rt field of the instruction in ID
- ID_uses_rt  in  1  ID instruction reads rt as a source
- EX_MemRead  in  1  instruction in EX is a load
- EX_rt  in  5  destination register of the load in EX
- EX_redirect  in  1  taken branch or jump resolved in EX
- ID_md_start  in  1  ID instruction is mult/div
- ID_md_div  in  1  with ID_md_start: 1 = divide, 0 = multiply
- ID_md_read  in  1  ID instruction is mfhi/mflo
- Stall  out  1  hold PC and IF/ID
- ID_bubble  out  1  zero control fields entering ID/EX
- IF_flush  out  1  squash IF/ID contents
- md_busy  out  1  multiply/divide operation in flight
- md_done  out  1  HI/LO write enable; one cycle
- stall_count  out  16  saturating count of cycles with Stall = 1

## Operation
Hazard terms, all combinational:
- load_use = EX_MemRead & (EX_rt != 0) & ((EX_rt == ID_rs) | (ID_uses_rt & (EX_rt == ID_rt)))
- md_struct = ID_md_start & (state == BUSY)
- md_raw = ID_md_read & (state != IDLE)

Output equations:
- Stall = !EX_redirect & (load_use | md_struct | md_raw)
- IF_flush = EX_redirect
- ID_bubble = Stall | EX_redirect
- EX_redirect has priority: the ID instruction is killed, so it cannot stall.

FSM: states IDLE, BUSY, DONE; 6-bit down-counter cnt.
- A start is accepted when ID_md_start & !Stall & !EX_redirect & state != BUSY.
- IDLE: on accept, go to BUSY and set cnt = (ID_md_div ? DIV_LAT : MUL_LAT) - 1.
- BUSY: if cnt == 1, go to DONE; otherwise decrement cnt.
- DONE: on accept, go to BUSY and load cnt as above (back-to-back issue). Otherwise go to IDLE.
- md_busy = (state == BUSY).
- md_done = (state == DONE).

Boundary behaviour:
- EX_redirect does not abort an operation already in flight, because it is older than the branch.
- EX_redirect does block acceptance of a start in ID that same cycle.
- stall_count increments by 1 in every cycle with Stall = 1 and holds at 0xFFFF.

Reset (asynchronous, active-low):
- State IDLE, cnt = 0, md_busy = 0, md_done = 0, stall_count = 0.
- Stall, ID_bubble and IF_flush follow their inputs combinationally.
- Reset mid-operation discards the operation; no md_done is produced.

## Timing
- Stall, ID_bubble and IF_flush are combinational from the inputs and state, in the same cycle. There are no flopped hazard outputs.
- md_busy, md_done and stall_count are registered (state decode or counter).
- Start accepted in cycle t with latency L:
  - md_busy is high in cycles t+1 .. t+L-1.
  - md_done is high in cycle t+L only.
  - HI/LO are readable from cycle t+L+1.
- mfhi/mflo in ID during cycles t+1 .. t+L stalls and issues in cycle t+L+1.
- A load-use stall lasts exactly 1 cycle, provided the EX instruction advances (the bubble clears EX_MemRead).
- A second mult/div in ID during BUSY stalls, then is accepted in the DONE cycle t+L.

## Test plan
- Load-use: EX_MemRead=1, EX_rt=5, ID_rs=5 -> Stall=1 and ID_bubble=1 for one cycle; stall_count goes 0->1. Same stimulus with EX_rt=0 -> Stall=0.
- Redirect beats stall: load_use true and EX_redirect=1 -> Stall=0, IF_flush=1, ID_bubble=1.
- Multiply: ID_md_start=1, ID_md_div=0 accepted at t -> md_busy=1 for t+1..t+3, md_done=1 at t+4, state IDLE at t+5. mfhi held in ID meanwhile -> Stall=1 for t+1..t+4.
- Back-to-back divide: divide accepted at t, second divide held in ID -> Stall=1 for t+1..t+31, accepted at t+32 with md_done=1, second md_done at t+64.
- Reset mid-divide: reset=0 at t+10 -> md_busy=0 immediately (asynchronous), no md_done afterwards, stall_count=0.
- Saturation: force 70000 consecutive stall cycles -> stall_count holds 0xFFFF.
